// File: rtl/pin_lock_pkg.sv
// Shared definitions for the PIN lock controller: FSM state encoding,
// seconds prescaler length, blank digit code and a BCD validity helper.
package pin_lock_pkg;

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        CHECK    = 3'd1,
        UNLOCKED = 3'd2,
        FAIL     = 3'd3,
        LOCKOUT  = 3'd4
    } lock_state_t;

    // clk_500Hz cycles per displayed second
    localparam int TICKS_PER_SEC = 500;
    localparam int PRE_W         = $clog2(TICKS_PER_SEC);

    // Digit code the 7-seg path uses for an empty position; never a PIN digit
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // True when every nibble of a PIN is a decimal digit 0..9
    function automatic logic is_bcd_pin(input logic [15:0] pin);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((pin[4*i +: 4] == BLANK_DIGIT) || (pin[4*i +: 4] > 4'd9)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag and a seconds prescaler.
// The counter holds (remaining ticks - 1); the prescaler and seconds
// counter are loaded so that secs always equals ceil(remaining / 500).
module lock_timer
    import pin_lock_pkg::*;
#(
    parameter int TW = 13
) (
    input  logic             clk_500Hz,
    input  logic             rst,
    input  logic             load,
    input  logic [TW-1:0]    load_val,
    input  logic [PRE_W-1:0] load_pre,
    input  logic [TW-1:0]    load_secs,
    input  logic             show_secs,
    output logic             done,
    output logic [3:0]       secs_left
);

    logic [TW-1:0]    cnt;
    logic [PRE_W-1:0] pre;
    logic [TW-1:0]    secs;
    logic             show;

    // Load on state entry, otherwise count down and stop at zero
    always_ff @(posedge clk_500Hz) begin
        if (rst) begin
            cnt  <= '0;
            pre  <= '0;
            secs <= '0;
            show <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            pre  <= load_pre;
            secs <= load_secs;
            show <= show_secs;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (pre == '0) begin
                pre  <= PRE_W'(TICKS_PER_SEC - 1);
                secs <= secs - 1'b1;
            end else begin
                pre <= pre - 1'b1;
            end
        end
    end

    // Done flag and saturated seconds display
    always_comb begin
        done      = (cnt == '0);
        secs_left = 4'd0;
        if (show) begin
            secs_left = (secs > TW'(9)) ? 4'd9 : secs[3:0];
        end
    end

endmodule

// File: rtl/pin_lock_ctrl.sv
// PIN lock controller: compares the PIN from the keypad decoder with the
// stored PIN and runs the lock FSM (unlock window, failed-attempt count,
// timed lockout). All outputs are registered from the next state.
// Optional PIN change while unlocked: define PIN_LOCK_CHANGE_EN.
module pin_lock_ctrl
    import pin_lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PIN   = 16'h1234,
    parameter int          MAX_TRIES     = 3,
    parameter int          UNLOCK_TICKS  = 2500,
    parameter int          FAIL_TICKS    = 500,
    parameter int          LOCKOUT_TICKS = 5000
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic [15:0] userPin,
    input  logic        validPin,
    output logic        status,
    output logic        unlocked,
    output logic        fail,
    output logic        alarm,
    output logic [3:0]  tries_left,
    output logic [3:0]  secs_left
);

    localparam int MAX_UF    = (UNLOCK_TICKS > FAIL_TICKS) ? UNLOCK_TICKS : FAIL_TICKS;
    localparam int MAX_TICKS = (MAX_UF > LOCKOUT_TICKS) ? MAX_UF : LOCKOUT_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [3:0]       TRIES_INIT   = 4'(MAX_TRIES);
    localparam logic [TW-1:0]    UNLOCK_LOAD  = TW'(UNLOCK_TICKS - 1);
    localparam logic [TW-1:0]    UNLOCK_SECS  = TW'((UNLOCK_TICKS - 1) / TICKS_PER_SEC + 1);
    localparam logic [PRE_W-1:0] UNLOCK_PRE   = PRE_W'((UNLOCK_TICKS - 1) % TICKS_PER_SEC);
    localparam logic [TW-1:0]    FAIL_LOAD    = TW'(FAIL_TICKS - 1);
    localparam logic [TW-1:0]    LOCKOUT_LOAD = TW'(LOCKOUT_TICKS - 1);
    localparam logic [TW-1:0]    LOCKOUT_SECS = TW'((LOCKOUT_TICKS - 1) / TICKS_PER_SEC + 1);
    localparam logic [PRE_W-1:0] LOCKOUT_PRE  = PRE_W'((LOCKOUT_TICKS - 1) % TICKS_PER_SEC);

    lock_state_t      state, next;
    logic [15:0]      pin_q;
    logic [15:0]      stored_pin;
    logic [3:0]       tries_q, tries_d;
    logic             timer_load;
    logic [TW-1:0]    load_val;
    logic [PRE_W-1:0] load_pre;
    logic [TW-1:0]    load_secs;
    logic             show_secs;
    logic             timer_done;

`ifdef PIN_LOCK_CHANGE_EN
    logic pin_we;

    // Stored PIN is rewritten only by a well-formed BCD entry while unlocked
    always_ff @(posedge clk_500Hz) begin
        if (rst) begin
            stored_pin <= DEFAULT_PIN;
        end else if (pin_we) begin
            stored_pin <= userPin;
        end
    end
`else
    assign stored_pin = DEFAULT_PIN;
`endif

    // Next state and next attempt count
    always_comb begin
        next    = state;
        tries_d = tries_q;
`ifdef PIN_LOCK_CHANGE_EN
        pin_we  = 1'b0;
`endif
        unique case (state)
            LOCKED: begin
                if (validPin) next = CHECK;
            end
            CHECK: begin
                if (pin_q == stored_pin) begin
                    next    = UNLOCKED;
                    tries_d = TRIES_INIT;
                end else if (tries_q > 4'd1) begin
                    next    = FAIL;
                    tries_d = tries_q - 4'd1;
                end else begin
                    next    = LOCKOUT;
                    tries_d = 4'd0;
                end
            end
            UNLOCKED: begin
                if (validPin) begin
                    next = LOCKED;
`ifdef PIN_LOCK_CHANGE_EN
                    pin_we = is_bcd_pin(userPin);
`endif
                end else if (timer_done) begin
                    next = LOCKED;
                end
            end
            FAIL: begin
                if (timer_done) next = LOCKED;
            end
            LOCKOUT: begin
                if (timer_done) begin
                    next    = LOCKED;
                    tries_d = TRIES_INIT;
                end
            end
            default: next = LOCKED;
        endcase
    end

    // Timer reload values for the state being entered
    always_comb begin
        timer_load = (next != state);
        load_val   = '0;
        load_pre   = '0;
        load_secs  = '0;
        show_secs  = 1'b0;
        case (next)
            UNLOCKED: begin
                load_val  = UNLOCK_LOAD;
                load_pre  = UNLOCK_PRE;
                load_secs = UNLOCK_SECS;
                show_secs = 1'b1;
            end
            FAIL: begin
                load_val = FAIL_LOAD;
            end
            LOCKOUT: begin
                load_val  = LOCKOUT_LOAD;
                load_pre  = LOCKOUT_PRE;
                load_secs = LOCKOUT_SECS;
                show_secs = 1'b1;
            end
            default: ;
        endcase
    end

    // State, captured PIN, attempt count and registered indicators
    always_ff @(posedge clk_500Hz) begin
        if (rst) begin
            state    <= LOCKED;
            pin_q    <= '0;
            tries_q  <= TRIES_INIT;
            status   <= 1'b0;
            unlocked <= 1'b0;
            fail     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state   <= next;
            tries_q <= tries_d;
            if ((state == LOCKED) && validPin) pin_q <= userPin;
            status   <= (next == CHECK) || (next == FAIL) || (next == LOCKOUT);
            unlocked <= (next == UNLOCKED);
            fail     <= (next == FAIL);
            alarm    <= (next == LOCKOUT);
        end
    end

    assign tries_left = tries_q;

    lock_timer #(
        .TW(TW)
    ) u_timer (
        .clk_500Hz (clk_500Hz),
        .rst       (rst),
        .load      (timer_load),
        .load_val  (load_val),
        .load_pre  (load_pre),
        .load_secs (load_secs),
        .show_secs (show_secs),
        .done      (timer_done),
        .secs_left (secs_left)
    );

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Directed self-checking bench for pin_lock_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pin_lock_ctrl;

    logic        clk_500Hz = 1'b0;
    logic        rst       = 1'b1;
    logic [15:0] userPin   = 16'h0000;
    logic        validPin  = 1'b0;
    logic        status, unlocked, fail, alarm;
    logic [3:0]  tries_left, secs_left;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock
    always #5 clk_500Hz = ~clk_500Hz;

    pin_lock_ctrl dut (
        .clk_500Hz  (clk_500Hz),
        .rst        (rst),
        .userPin    (userPin),
        .validPin   (validPin),
        .status     (status),
        .unlocked   (unlocked),
        .fail       (fail),
        .alarm      (alarm),
        .tries_left (tries_left),
        .secs_left  (secs_left)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk_500Hz);
    endtask

    // One-cycle PIN strobe; returns at the falling edge after the strobe edge
    task automatic strobe(input logic [15:0] p);
        userPin  = p;
        validPin = 1'b1;
        tick(1);
        validPin = 1'b0;
    endtask

    // Wait (bounded) until FAIL/LOCKOUT indication has cleared
    task automatic wait_clear(output bit ok);
        int n;
        n = 0;
        while (((fail === 1'b1) || (alarm === 1'b1)) && (n < 6000)) begin
            tick(1);
            n++;
        end
        ok = (fail === 1'b0) && (alarm === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        validPin = 1'b0;
        tick(2);
        rst = 1'b0;
        n_checks++;
        if ({status, unlocked, fail, alarm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {status, unlocked, fail, alarm});
        end
        n_checks++;
        if (tries_left !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_tries: got %0d want 3", tries_left);
        end
        n_checks++;
        if (secs_left !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_secs: got %0d want 0", secs_left);
        end
    endtask

    task automatic test_unlock();
        int hi;
        strobe(16'h1234);
        n_checks++;
        if ((status !== 1'b1) || (unlocked !== 1'b0)) begin
            n_fail++;
            $display("FAIL unlock_check_cycle: got status=%b unlocked=%b want 1 0", status, unlocked);
        end
        tick(1);
        n_checks++;
        if ((unlocked !== 1'b1) || (status !== 1'b0) || (secs_left !== 4'd5) || (tries_left !== 4'd3)) begin
            n_fail++;
            $display("FAIL unlock_entry: got unl=%b st=%b secs=%0d tries=%0d want 1 0 5 3",
                     unlocked, status, secs_left, tries_left);
        end
        hi = 1;
        while ((unlocked === 1'b1) && (hi < 3000)) begin
            if (hi == 501) begin
                n_checks++;
                if (secs_left !== 4'd4) begin
                    n_fail++;
                    $display("FAIL unlock_secs_mid: got %0d want 4", secs_left);
                end
            end
            if (hi == 2500) begin
                n_checks++;
                if (secs_left !== 4'd1) begin
                    n_fail++;
                    $display("FAIL unlock_secs_last: got %0d want 1", secs_left);
                end
            end
            tick(1);
            if (unlocked === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== 2500) begin
            n_fail++;
            $display("FAIL unlock_window: got %0d cycles want 2500", hi);
        end
        n_checks++;
        if ((secs_left !== 4'd0) || (status !== 1'b0)) begin
            n_fail++;
            $display("FAIL unlock_expired: got secs=%0d st=%b want 0 0", secs_left, status);
        end
    endtask

    task automatic test_fail_lockout();
        int  hi;
        bit  saw_unlock;
        for (int i = 0; i < 2; i++) begin
            strobe(16'h1111);
            tick(1);
            n_checks++;
            if ((fail !== 1'b1) || (status !== 1'b1) || (tries_left !== 4'(2 - i)) || (secs_left !== 4'd0)) begin
                n_fail++;
                $display("FAIL wrong_pin_%0d: got fail=%b st=%b tries=%0d secs=%0d want 1 1 %0d 0",
                         i, fail, status, tries_left, secs_left, 2 - i);
            end
            hi = 1;
            while ((fail === 1'b1) && (hi < 1000)) begin
                tick(1);
                if (fail === 1'b1) hi++;
            end
            n_checks++;
            if ((hi !== 500) || (tries_left !== 4'(2 - i))) begin
                n_fail++;
                $display("FAIL fail_pulse_%0d: got %0d cycles tries=%0d want 500 %0d", i, hi, tries_left, 2 - i);
            end
        end
        strobe(16'h1111);
        tick(1);
        n_checks++;
        if ((alarm !== 1'b1) || (status !== 1'b1) || (tries_left !== 4'd0) || (secs_left !== 4'd9) || (fail !== 1'b0)) begin
            n_fail++;
            $display("FAIL lockout_entry: got al=%b st=%b tries=%0d secs=%0d fail=%b want 1 1 0 9 0",
                     alarm, status, tries_left, secs_left, fail);
        end
        hi = 1;
        saw_unlock = 1'b0;
        while ((alarm === 1'b1) && (hi < 6000)) begin
            if (hi == 4001) begin
                n_checks++;
                if (secs_left !== 4'd2) begin
                    n_fail++;
                    $display("FAIL lockout_secs: got %0d want 2", secs_left);
                end
            end
            userPin  = 16'h1234;
            validPin = (hi == 100) || (hi == 101);
            tick(1);
            validPin = 1'b0;
            if (unlocked === 1'b1) saw_unlock = 1'b1;
            if (alarm === 1'b1) hi++;
        end
        n_checks++;
        if ((hi !== 5000) || saw_unlock) begin
            n_fail++;
            $display("FAIL lockout_window: got %0d cycles unlock_seen=%b want 5000 0", hi, saw_unlock);
        end
        n_checks++;
        if ((tries_left !== 4'd3) || (status !== 1'b0) || (unlocked !== 1'b0)) begin
            n_fail++;
            $display("FAIL lockout_expired: got tries=%0d st=%b unl=%b want 3 0 0", tries_left, status, unlocked);
        end
    endtask

    task automatic test_partial_then_success();
        bit ok;
        strobe(16'h1111);
        tick(1);
        n_checks++;
        if ((fail !== 1'b1) || (tries_left !== 4'd2)) begin
            n_fail++;
            $display("FAIL partial_fail: got fail=%b tries=%0d want 1 2", fail, tries_left);
        end
        wait_clear(ok);
        n_checks++;
        if (!ok || (tries_left !== 4'd2)) begin
            n_fail++;
            $display("FAIL partial_persist: got cleared=%b tries=%0d want 1 2", ok, tries_left);
        end
        strobe(16'h1234);
        tick(1);
        n_checks++;
        if ((unlocked !== 1'b1) || (tries_left !== 4'd3)) begin
            n_fail++;
            $display("FAIL partial_restore: got unl=%b tries=%0d want 1 3", unlocked, tries_left);
        end
    endtask

    // Entered while UNLOCKED; leaves LOCKED with tries_left=3 and PIN 1234
    task automatic test_strobe_while_unlocked();
        bit ok;
        strobe(16'h5678);
        n_checks++;
        if ((unlocked !== 1'b0) || (status !== 1'b0)) begin
            n_fail++;
            $display("FAIL relock: got unl=%b st=%b want 0 0", unlocked, status);
        end
`ifdef PIN_LOCK_CHANGE_EN
        strobe(16'h1234);
        tick(1);
        n_checks++;
        if ((fail !== 1'b1) || (tries_left !== 4'd2)) begin
            n_fail++;
            $display("FAIL old_pin_rejected: got fail=%b tries=%0d want 1 2", fail, tries_left);
        end
        wait_clear(ok);
        strobe(16'h5678);
        tick(1);
        n_checks++;
        if ((unlocked !== 1'b1) || (tries_left !== 4'd3) || !ok) begin
            n_fail++;
            $display("FAIL new_pin_accepted: got unl=%b tries=%0d want 1 3", unlocked, tries_left);
        end
        strobe(16'h12A4);
        n_checks++;
        if (unlocked !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_bcd_relock: got unl=%b want 0", unlocked);
        end
        strobe(16'h5678);
        tick(1);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_bcd_ignored: got unl=%b want 1", unlocked);
        end
        strobe(16'h1234);
        strobe(16'h1234);
        tick(1);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++;
            $display("FAIL pin_restored: got unl=%b want 1", unlocked);
        end
        strobe(16'h1234);
`else
        strobe(16'h5678);
        tick(1);
        n_checks++;
        if ((fail !== 1'b1) || (tries_left !== 4'd2)) begin
            n_fail++;
            $display("FAIL pin_unchanged: got fail=%b tries=%0d want 1 2", fail, tries_left);
        end
        wait_clear(ok);
        strobe(16'h1234);
        tick(1);
        n_checks++;
        if ((unlocked !== 1'b1) || (tries_left !== 4'd3) || !ok) begin
            n_fail++;
            $display("FAIL default_pin_ok: got unl=%b tries=%0d want 1 3", unlocked, tries_left);
        end
        strobe(16'h1234);
`endif
        n_checks++;
        if ((unlocked !== 1'b0) || (tries_left !== 4'd3)) begin
            n_fail++;
            $display("FAIL relock_final: got unl=%b tries=%0d want 0 3", unlocked, tries_left);
        end
    endtask

    task automatic test_check_drop();
        bit ok;
        userPin  = 16'h1111;
        validPin = 1'b1;
        tick(1);
        userPin  = 16'h1234;
        n_checks++;
        if (status !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_in_check: got st=%b want 1", status);
        end
        tick(1);
        validPin = 1'b0;
        n_checks++;
        if ((fail !== 1'b1) || (tries_left !== 4'd2) || (unlocked !== 1'b0)) begin
            n_fail++;
            $display("FAIL drop_result: got fail=%b tries=%0d unl=%b want 1 2 0", fail, tries_left, unlocked);
        end
        wait_clear(ok);
        tick(3);
        n_checks++;
        if (!ok || (unlocked !== 1'b0) || (status !== 1'b0) || (tries_left !== 4'd2)) begin
            n_fail++;
            $display("FAIL drop_after: got unl=%b st=%b tries=%0d want 0 0 2", unlocked, status, tries_left);
        end
    endtask

    task automatic test_reset_mid_lockout();
        bit ok;
        for (int i = 0; i < 2; i++) begin
            strobe(16'h9999);
            tick(1);
            if (alarm !== 1'b1) wait_clear(ok);
        end
        n_checks++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL lockout_reached: got al=%b want 1", alarm);
        end
        tick(999);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ((alarm !== 1'b0) || (status !== 1'b0) || (tries_left !== 4'd3) || (secs_left !== 4'd0)) begin
            n_fail++;
            $display("FAIL reset_lockout: got al=%b st=%b tries=%0d secs=%0d want 0 0 3 0",
                     alarm, status, tries_left, secs_left);
        end
        rst = 1'b0;
        strobe(16'h1234);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        n_checks++;
        if ((unlocked !== 1'b0) || (status !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_check: got unl=%b st=%b want 0 0", unlocked, status);
        end
        strobe(16'h1234);
        tick(1);
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++;
            $display("FAIL unlock_after_reset: got unl=%b want 1", unlocked);
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_partial_then_success();
        test_strobe_while_unlocked();
        test_check_drop();
        test_reset_mid_lockout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
